// File: rtl/rv32_isa_pkg.sv
// Shared RV32I definitions used by the instruction encoder and the opcode
// decoder: symbolic operation codes, major opcodes, funct3/funct7 fields,
// instruction formats, immediate check classes and the per-operation
// encoding attributes.
package rv32_isa_pkg;

    // One code per RV32I instruction, plus the li pseudo-instruction.
    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_FENCE_I,
        OP_LI
    } enc_op_t;

    // Base instruction formats.
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    // Immediate legality classes (derived from the format plus the few
    // instructions whose immediate field has a special meaning).
    typedef enum logic [2:0] {
        CHK_NONE, CHK_S12, CHK_B13, CHK_J21, CHK_U, CHK_SHAMT, CHK_FENCE
    } imm_chk_t;

    // Source of the 12-bit I-type immediate field.
    typedef enum logic [1:0] {IMM_REQ, IMM_FENCE, IMM_ZERO, IMM_ONE} imm_src_t;

    // Major opcodes.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU funct3.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    // Load/store width funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Branch funct3.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    // System / fence funct3.
    localparam logic [2:0] F3_PRIV    = 3'b000;
    localparam logic [2:0] F3_CSRRW   = 3'b001;
    localparam logic [2:0] F3_CSRRS   = 3'b010;
    localparam logic [2:0] F3_CSRRC   = 3'b011;
    localparam logic [2:0] F3_CSRRWI  = 3'b101;
    localparam logic [2:0] F3_CSRRSI  = 3'b110;
    localparam logic [2:0] F3_CSRRCI  = 3'b111;
    localparam logic [2:0] F3_FENCE   = 3'b000;
    localparam logic [2:0] F3_FENCE_I = 3'b001;

    // funct7.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Everything needed to assemble one base instruction word.
    typedef struct packed {
        logic       legal;
        fmt_t       fmt;
        imm_chk_t   chk;
        imm_src_t   imm_src;
        logic       zero_regs;  // rd and rs1 forced to x0
        logic       shamt;      // rs2 field carries imm[4:0]
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_info_t;

    // True when a 32-bit value is representable as a signed 12-bit immediate.
    function automatic logic fits_s12(input logic [31:0] v);
        return (&v[31:11]) || !(|v[31:11]);
    endfunction

    function automatic op_info_t mk_info(input fmt_t fmt, input imm_chk_t chk,
                                         input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7);
        op_info_t info;
        info           = '0;
        info.legal     = 1'b1;
        info.fmt       = fmt;
        info.chk       = chk;
        info.imm_src   = IMM_REQ;
        info.opcode    = opc;
        info.funct3    = f3;
        info.funct7    = f7;
        return info;
    endfunction

    // Map a base instruction code to its encoding attributes. OP_LI and
    // undefined codes come back with legal = 0; the li pseudo-instruction
    // is handled by the encoder itself.
    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '0;
        case (op)
            OP_ADD:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_ADD_SUB, F7_BASE);
            OP_SUB:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_ADD_SUB, F7_ALT);
            OP_SLL:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_SLL, F7_BASE);
            OP_SLT:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_SLT, F7_BASE);
            OP_SLTU:   info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_SLTU, F7_BASE);
            OP_XOR:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_XOR, F7_BASE);
            OP_SRL:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_SRL_SRA, F7_BASE);
            OP_SRA:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_SRL_SRA, F7_ALT);
            OP_OR:     info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_OR, F7_BASE);
            OP_AND:    info = mk_info(FMT_R, CHK_NONE, OPC_OP, F3_AND, F7_BASE);
            OP_ADDI:   info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_ADD_SUB, F7_BASE);
            OP_SLTI:   info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_SLT, F7_BASE);
            OP_SLTIU:  info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_SLTU, F7_BASE);
            OP_XORI:   info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_XOR, F7_BASE);
            OP_ORI:    info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_OR, F7_BASE);
            OP_ANDI:   info = mk_info(FMT_I, CHK_S12, OPC_OP_IMM, F3_AND, F7_BASE);
            OP_SLLI:   info = mk_info(FMT_R, CHK_SHAMT, OPC_OP_IMM, F3_SLL, F7_BASE);
            OP_SRLI:   info = mk_info(FMT_R, CHK_SHAMT, OPC_OP_IMM, F3_SRL_SRA, F7_BASE);
            OP_SRAI:   info = mk_info(FMT_R, CHK_SHAMT, OPC_OP_IMM, F3_SRL_SRA, F7_ALT);
            OP_LB:     info = mk_info(FMT_I, CHK_S12, OPC_LOAD, F3_B, F7_BASE);
            OP_LH:     info = mk_info(FMT_I, CHK_S12, OPC_LOAD, F3_H, F7_BASE);
            OP_LW:     info = mk_info(FMT_I, CHK_S12, OPC_LOAD, F3_W, F7_BASE);
            OP_LBU:    info = mk_info(FMT_I, CHK_S12, OPC_LOAD, F3_BU, F7_BASE);
            OP_LHU:    info = mk_info(FMT_I, CHK_S12, OPC_LOAD, F3_HU, F7_BASE);
            OP_SB:     info = mk_info(FMT_S, CHK_S12, OPC_STORE, F3_B, F7_BASE);
            OP_SH:     info = mk_info(FMT_S, CHK_S12, OPC_STORE, F3_H, F7_BASE);
            OP_SW:     info = mk_info(FMT_S, CHK_S12, OPC_STORE, F3_W, F7_BASE);
            OP_BEQ:    info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BEQ, F7_BASE);
            OP_BNE:    info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BNE, F7_BASE);
            OP_BLT:    info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BLT, F7_BASE);
            OP_BGE:    info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BGE, F7_BASE);
            OP_BLTU:   info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BLTU, F7_BASE);
            OP_BGEU:   info = mk_info(FMT_B, CHK_B13, OPC_BRANCH, F3_BGEU, F7_BASE);
            OP_LUI:    info = mk_info(FMT_U, CHK_U, OPC_LUI, 3'b000, F7_BASE);
            OP_AUIPC:  info = mk_info(FMT_U, CHK_U, OPC_AUIPC, 3'b000, F7_BASE);
            OP_JAL:    info = mk_info(FMT_J, CHK_J21, OPC_JAL, 3'b000, F7_BASE);
            OP_JALR:   info = mk_info(FMT_I, CHK_S12, OPC_JALR, 3'b000, F7_BASE);
            OP_FENCE:  info = mk_info(FMT_I, CHK_FENCE, OPC_MISC_MEM, F3_FENCE, F7_BASE);
            OP_ECALL:  info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_PRIV, F7_BASE);
            OP_EBREAK: info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_PRIV, F7_BASE);
            OP_CSRRW:  info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRW, F7_BASE);
            OP_CSRRS:  info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRS, F7_BASE);
            OP_CSRRC:  info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRC, F7_BASE);
            OP_CSRRWI: info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRWI, F7_BASE);
            OP_CSRRSI: info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRSI, F7_BASE);
            OP_CSRRCI: info = mk_info(FMT_I, CHK_NONE, OPC_SYSTEM, F3_CSRRCI, F7_BASE);
            OP_FENCE_I: info = mk_info(FMT_I, CHK_NONE, OPC_MISC_MEM, F3_FENCE_I, F7_BASE);
            default:   info = '0;
        endcase
        // Fixed-field instructions: registers are x0, immediate is synthesized.
        case (op)
            OP_SLLI, OP_SRLI, OP_SRAI: info.shamt = 1'b1;
            OP_FENCE: begin
                info.imm_src   = IMM_FENCE;
                info.zero_regs = 1'b1;
            end
            OP_ECALL, OP_FENCE_I: begin
                info.imm_src   = IMM_ZERO;
                info.zero_regs = 1'b1;
            end
            OP_EBREAK: begin
                info.imm_src   = IMM_ONE;
                info.zero_regs = 1'b1;
            end
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rv32_imm_check.sv
// Combinational immediate range check. The check class is derived from the
// instruction format (with shift, fence and CSR refinements); imm_ok is high
// when req_imm can be encoded without loss.
module rv32_imm_check
    import rv32_isa_pkg::*;
(
    input  imm_chk_t    chk,
    input  logic [31:0] imm,
    output logic        imm_ok
);

    // Select the legality rule for the requested check class.
    always_comb begin
        imm_ok = 1'b1;
        case (chk)
            CHK_S12:   imm_ok = fits_s12(imm);
            CHK_B13:   imm_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            CHK_J21:   imm_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            CHK_U:     imm_ok = (imm[11:0] == 12'h000);
            CHK_SHAMT: imm_ok = (imm[31:5] == 27'd0);
            CHK_FENCE: imm_ok = (imm[31:8] == 24'd0);
            default:   imm_ok = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: symbolic request in, 32-bit machine word out,
// both over valid/ready. Illegal requests are consumed and flagged with a
// one-cycle err_imm/err_op pulse instead of producing a word.
// Optional feature macro: RV32_ENCODER_PSEUDO_EN enables li expansion into
// lui + addi; without it OP_LI is reported as an unsupported operation.
module rv32_instr_encoder
    import rv32_isa_pkg::*;
#(
    parameter int COUNT_W = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [5:0]         req_op,
    input  logic [4:0]         req_rd,
    input  logic [4:0]         req_rs1,
    input  logic [4:0]         req_rs2,
    input  logic [31:0]        req_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_last,
    output logic               err_imm,
    output logic               err_op,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EMIT  = 2'd1;
`ifdef RV32_ENCODER_PSEUDO_EN
    localparam logic [1:0] EMIT2 = 2'd2;
`endif

    logic [1:0]         state_reg;
    logic               out_valid_reg;
    logic [31:0]        out_instr_reg;
    logic               out_last_reg;
    logic               err_imm_reg;
    logic               err_op_reg;
    logic [COUNT_W-1:0] count_reg;
`ifdef RV32_ENCODER_PSEUDO_EN
    logic [31:0]        pending_reg;
    logic [31:0]        second_word;
    logic [19:0]        li_hi;
    logic               is_li;
`endif

    op_info_t    info;
    logic        imm_ok;
    logic        op_ok;
    logic        accept;
    logic        out_hs;
    logic        load_new;
    logic [11:0] imm12;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [31:0] base_word;
    logic [31:0] first_word;
    logic        first_last;

    assign info = decode_op(req_op);

    rv32_imm_check u_imm_check (
        .chk    (info.chk),
        .imm    (req_imm),
        .imm_ok (imm_ok)
    );

`ifdef RV32_ENCODER_PSEUDO_EN
    assign is_li = (req_op == OP_LI);
    assign op_ok = info.legal || is_li;
`else
    assign op_ok = info.legal;
`endif

    // New requests are taken when idle, or in the same cycle the final
    // word of the previous request drains, giving one word per cycle.
    assign req_ready = (state_reg == IDLE) ||
                       ((state_reg == EMIT) && out_ready && out_last_reg);
    assign accept    = req_valid && req_ready;
    assign out_hs    = out_valid_reg && out_ready;
    assign load_new  = accept && op_ok && imm_ok;

    assign out_valid   = out_valid_reg;
    assign out_instr   = out_instr_reg;
    assign out_last    = out_last_reg;
    assign err_imm     = err_imm_reg;
    assign err_op      = err_op_reg;
    assign instr_count = count_reg;

    // Assemble the base-format word from the request fields.
    always_comb begin
        imm12 = req_imm[11:0];
        case (info.imm_src)
            IMM_FENCE: imm12 = {4'b0000, req_imm[7:0]};
            IMM_ZERO:  imm12 = 12'h000;
            IMM_ONE:   imm12 = 12'h001;
            default:   imm12 = req_imm[11:0];
        endcase
        rd_f  = info.zero_regs ? 5'd0 : req_rd;
        rs1_f = info.zero_regs ? 5'd0 : req_rs1;
        rs2_f = info.shamt ? req_imm[4:0] : req_rs2;
        case (info.fmt)
            FMT_R:   base_word = {info.funct7, rs2_f, rs1_f, info.funct3, rd_f, info.opcode};
            FMT_I:   base_word = {imm12, rs1_f, info.funct3, rd_f, info.opcode};
            FMT_S:   base_word = {req_imm[11:5], rs2_f, rs1_f, info.funct3,
                                  req_imm[4:0], info.opcode};
            FMT_B:   base_word = {req_imm[12], req_imm[10:5], rs2_f, rs1_f, info.funct3,
                                  req_imm[4:1], req_imm[11], info.opcode};
            FMT_U:   base_word = {req_imm[31:12], rd_f, info.opcode};
            FMT_J:   base_word = {req_imm[20], req_imm[10:1], req_imm[11],
                                  req_imm[19:12], rd_f, info.opcode};
            default: base_word = 32'h0000_0000;
        endcase
    end

    // Choose the first word (and the pending second word for li).
    always_comb begin
        first_word = base_word;
        first_last = 1'b1;
`ifdef RV32_ENCODER_PSEUDO_EN
        // (imm + 0x800) >> 12 rounds so the sign-extended addi low part
        // recombines to imm.
        li_hi       = req_imm[31:12] + {19'd0, req_imm[11]};
        second_word = {req_imm[11:0], req_rd, F3_ADD_SUB, req_rd, OPC_OP_IMM};
        if (is_li) begin
            if (fits_s12(req_imm)) begin
                first_word = {req_imm[11:0], 5'd0, F3_ADD_SUB, req_rd, OPC_OP_IMM};
            end else begin
                first_word = {li_hi, req_rd, OPC_LUI};
                first_last = (req_imm[11:0] == 12'h000);
            end
        end
`endif
    end

    // Encoder FSM, output register, error pulses and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_instr_reg <= 32'h0000_0000;
            out_last_reg  <= 1'b0;
            err_imm_reg   <= 1'b0;
            err_op_reg    <= 1'b0;
            count_reg     <= '0;
`ifdef RV32_ENCODER_PSEUDO_EN
            pending_reg   <= 32'h0000_0000;
`endif
        end else begin
            err_imm_reg <= accept && op_ok && !imm_ok;
            err_op_reg  <= accept && !op_ok;
            if (out_hs) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (load_new) begin
                        state_reg     <= EMIT;
                        out_valid_reg <= 1'b1;
                        out_instr_reg <= first_word;
                        out_last_reg  <= first_last;
`ifdef RV32_ENCODER_PSEUDO_EN
                        pending_reg   <= second_word;
`endif
                    end
                end
                EMIT: begin
                    if (out_hs) begin
`ifdef RV32_ENCODER_PSEUDO_EN
                        if (!out_last_reg) begin
                            state_reg     <= EMIT2;
                            out_valid_reg <= 1'b0;
                        end else
`endif
                        if (load_new) begin
                            out_instr_reg <= first_word;
                            out_last_reg  <= first_last;
`ifdef RV32_ENCODER_PSEUDO_EN
                            pending_reg   <= second_word;
`endif
                        end else begin
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                        end
                    end
                end
`ifdef RV32_ENCODER_PSEUDO_EN
                EMIT2: begin
                    state_reg     <= EMIT;
                    out_valid_reg <= 1'b1;
                    out_instr_reg <= pending_reg;
                    out_last_reg  <= 1'b1;
                end
`endif
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
